// File: rtl/d_cache_pkg.sv
// Shared definitions for the pipeline/cache family: word-address field widths
// and the cache controller state encoding.
package d_cache_pkg;

  // Processor word address: {tag, index, offset}
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned ADDR_W      = 30;
  localparam int unsigned OFFSET_W    = 2;
  localparam int unsigned INDEX_W     = 3;
  localparam int unsigned TAG_W       = 25;
  localparam int unsigned LINE_ADDR_W = ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_t;

endpackage : d_cache_pkg

// File: rtl/d_cache_array.sv
// cache_array: tag/valid/dirty/data storage for the direct-mapped cache.
// Combinational read of one line; synchronous word write (sets dirty) or
// full line fill (sets valid, clears dirty, writes tag). Valid/dirty clear
// on synchronous active-low reset; tag and data are not reset.
//   clk, rst_n            clock, synchronous active-low reset
//   idx                   line index for read and write
//   rd_valid/dirty/tag/line  state of line idx
//   word_we/sel/data      single-word store into line idx
//   fill_we/tag/line      line fill into idx
module cache_array
  import d_cache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 8,
  parameter int unsigned IDX_W     = 3,
  parameter int unsigned TAG_BITS  = 25,
  parameter int unsigned LINE_W    = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_W-1:0]    idx,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [LINE_W-1:0]   rd_line,
  input  logic                word_we,
  input  logic [OFFSET_W-1:0] word_sel,
  input  logic [WORD_W-1:0]   word_data,
  input  logic                fill_we,
  input  logic [TAG_BITS-1:0] fill_tag,
  input  logic [LINE_W-1:0]   fill_line
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  // Combinational read port
  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = data_q[idx];

  // Line state bits; a fill takes priority (the two never coincide)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data storage, unreset
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_line;
    end else if (word_we) begin
      data_q[idx][32'(word_sel) * WORD_W +: WORD_W] <= word_data;
    end
  end

endmodule : cache_array

// File: rtl/d_cache.sv
// d_cache: write-back, write-allocate, direct-mapped data cache.
// Hits complete in the request cycle; misses stall the processor while the
// controller writes back a dirty victim (WRITEBACK) and fills the line
// (ALLOCATE), after which the held request hits.
//   clk, rst_n                      clock, synchronous active-low reset
//   proc_read/write/addr/wdata      processor request (held while stalled)
//   proc_stall, proc_rdata          stall and same-cycle load data
//   mem_read/write/addr/wdata       line fill / write-back request
//   mem_rdata, mem_ready            fill data, one-cycle completion pulse
module d_cache
  import d_cache_pkg::*;
#(
  parameter int unsigned NUM_LINES      = 8,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               proc_read,
  input  logic                               proc_write,
  input  logic [ADDR_W-1:0]                  proc_addr,
  input  logic [WORD_W-1:0]                  proc_wdata,
  output logic                               proc_stall,
  output logic [WORD_W-1:0]                  proc_rdata,
  output logic                               mem_read,
  output logic                               mem_write,
  output logic [LINE_ADDR_W-1:0]             mem_addr,
  output logic [WORDS_PER_LINE*WORD_W-1:0]   mem_wdata,
  input  logic [WORDS_PER_LINE*WORD_W-1:0]   mem_rdata,
  input  logic                               mem_ready
);

  localparam int unsigned IDX_W    = $clog2(NUM_LINES);
  localparam int unsigned TAG_BITS = ADDR_W - OFFSET_W - IDX_W;
  localparam int unsigned LINE_W   = WORDS_PER_LINE * WORD_W;

  cache_state_t state_q, state_d;

  logic [LINE_ADDR_W-1:0] miss_line_q;
  logic                   miss_capture;

  logic [OFFSET_W-1:0] req_off;
  logic [IDX_W-1:0]    req_idx;
  logic [TAG_BITS-1:0] req_tag;
  logic [IDX_W-1:0]    miss_idx;
  logic [IDX_W-1:0]    arr_idx;
  logic                req;
  logic                hit;

  logic                rd_valid;
  logic                rd_dirty;
  logic [TAG_BITS-1:0] rd_tag;
  logic [LINE_W-1:0]   rd_line;
  logic                word_we;
  logic                fill_we;

  // Address decode
  assign req_off  = proc_addr[OFFSET_W-1:0];
  assign req_idx  = proc_addr[OFFSET_W +: IDX_W];
  assign req_tag  = proc_addr[ADDR_W-1 -: TAG_BITS];
  assign miss_idx = miss_line_q[IDX_W-1:0];
  assign req      = proc_read | proc_write;

  // Idle looks up the live request; a miss in progress works on the latched line
  assign arr_idx = (state_q == IDLE) ? req_idx : miss_idx;
  assign hit     = rd_valid && (rd_tag == req_tag);

  cache_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_BITS  (TAG_BITS),
    .LINE_W    (LINE_W)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx       (arr_idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .word_we   (word_we),
    .word_sel  (req_off),
    .word_data (proc_wdata),
    .fill_we   (fill_we),
    .fill_tag  (miss_line_q[LINE_ADDR_W-1 -: TAG_BITS]),
    .fill_line (mem_rdata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Missing line address, latched on the cycle the miss leaves IDLE so the
  // memory address cannot move during the transaction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      miss_line_q <= '0;
    end else if (miss_capture) begin
      miss_line_q <= proc_addr[ADDR_W-1:OFFSET_W];
    end
  end

  // Next state, stall and array write enables; read+write counts as a write
  always_comb begin
    state_d      = state_q;
    proc_stall   = 1'b0;
    word_we      = 1'b0;
    fill_we      = 1'b0;
    miss_capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            word_we = proc_write;
          end else begin
            proc_stall   = 1'b1;
            miss_capture = 1'b1;
            state_d      = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        proc_stall = 1'b1;
        if (mem_ready) begin
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        proc_stall = 1'b1;
        if (mem_ready) begin
          fill_we = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory requests decode straight from the state register; held low in reset
  assign mem_write  = rst_n && (state_q == WRITEBACK);
  assign mem_read   = rst_n && (state_q == ALLOCATE);
  assign mem_addr   = (state_q == WRITEBACK) ? {rd_tag, miss_idx} : miss_line_q;
  assign mem_wdata  = rd_line;
  assign proc_rdata = rd_line[32'(req_off) * WORD_W +: WORD_W];

endmodule : d_cache

// File: tb/tb_d_cache.sv
// Self-checking bench for d_cache: a reactive memory model with a scoreboard
// of expected memory transactions and load data, plus a reference view of
// architectural memory used to derive every expected word and line.
module tb_d_cache;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  d_cache #(.NUM_LINES(8), .WORDS_PER_LINE(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         is_wr;
    logic [27:0]  addr;
    logic [127:0] data;
  } mem_txn_t;

  mem_txn_t     mq[$];
  logic [31:0]  rd_q[$];
  logic [127:0] mem_line [logic [27:0]];
  logic [31:0]  ref_mem  [logic [29:0]];

  int n_vec = 0;
  int n_err = 0;
  int mem_delay = 2;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Backing memory: untouched lines hold an address-derived pattern
  function automatic logic [127:0] get_line(input logic [27:0] la);
    logic [127:0] l;
    if (mem_line.exists(la)) return mem_line[la];
    for (int w = 0; w < 4; w++) l[32*w +: 32] = {la, 2'(w)} ^ 32'h5A5A_5A5A;
    return l;
  endfunction

  // Architectural value of a word
  function automatic logic [31:0] ref_rd(input logic [29:0] a);
    logic [127:0] l;
    if (ref_mem.exists(a)) return ref_mem[a];
    l = get_line(a[29:2]);
    return l[32*int'(a[1:0]) +: 32];
  endfunction

  task automatic exp_fill(input logic [27:0] la);
    mem_txn_t t;
    t.is_wr = 1'b0; t.addr = la; t.data = '0;
    mq.push_back(t);
  endtask

  task automatic exp_wb(input logic [27:0] la);
    mem_txn_t t;
    t.is_wr = 1'b1; t.addr = la;
    for (int w = 0; w < 4; w++) t.data[32*w +: 32] = ref_rd({la, 2'(w)});
    mq.push_back(t);
  endtask

  // Memory responder: checks each request against the scoreboard, holds
  // mem_ready off for mem_delay cycles, checks request stability and drop
  bit          active = 0;
  bit          last_wr;
  int          cnt;
  logic [27:0] act_addr;
  logic [127:0] act_wdata;

  always @(negedge clk) begin
    mem_txn_t t;
    if (!rst_n) begin
      active    = 0;
      cnt       = 0;
      mem_ready = 1'b0;
    end else begin
      if (mem_ready) begin
        mem_ready = 1'b0;
        active    = 0;
        chk("mem_drop", last_wr ? mem_write : mem_read, 1'b0);
      end
      if (!active && (mem_read || mem_write)) begin
        active   = 1;
        cnt      = 0;
        last_wr  = mem_write;
        act_addr = mem_addr;
        act_wdata = mem_wdata;
        if (mq.size() == 0) begin
          chk("mem_unexpected", {mem_write, mem_addr}, '0);
        end else begin
          t = mq.pop_front();
          chk("mem_kind_addr", {mem_write, mem_read, mem_addr}, {t.is_wr, ~t.is_wr, t.addr});
          if (t.is_wr) chk("mem_wdata", mem_wdata, t.data);
        end
        if (!mem_write) mem_rdata = get_line(mem_addr);
      end else if (active) begin
        cnt++;
        chk("mem_hold", {last_wr ? mem_write : mem_read, proc_stall, mem_addr},
            {1'b1, 1'b1, act_addr});
      end
      if (active && cnt == mem_delay) begin
        mem_ready = 1'b1;
        if (last_wr) mem_line[act_addr] = act_wdata;
      end
    end
  end

  // One processor access; n_txn = memory transactions the access must cause
  task automatic access(input bit rd, input bit wr, input logic [29:0] a,
                        input logic [31:0] wd, input int n_txn);
    int cyc = 0;
    int exp_len;
    logic [31:0] e;
    exp_len = (n_txn == 0) ? 0 : 1 + n_txn * (mem_delay + 1);
    @(posedge clk); #1;
    proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = wd;
    if (!wr) rd_q.push_back(ref_rd(a));
    @(negedge clk);
    chk("stall_first", proc_stall, n_txn != 0);
    while (proc_stall && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    chk("stall_len", cyc, exp_len);
    if (!wr) begin
      e = rd_q.pop_front();
      chk("rdata", proc_rdata, e);
    end else begin
      ref_mem[a] = wd;
    end
    @(posedge clk); #1;
    proc_read = 1'b0; proc_write = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; proc_read = 1'b0; proc_write = 1'b0;
    proc_addr = '0; proc_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset and idle state
    @(negedge clk);
    chk("rst_state", {proc_stall, mem_read, mem_write}, 3'b000);
    repeat (2) @(negedge clk);
    chk("idle_state", {proc_stall, mem_read, mem_write}, 3'b000);

    // Cold read: single fill of line 0x4
    exp_fill(28'h4);
    access(1, 0, 30'h10, '0, 1);

    // Write hit then read hit, no stall
    access(0, 1, 30'h10, 32'hDEAD_BEEF, 0);
    access(1, 0, 30'h10, '0, 0);
    access(1, 0, 30'h11, '0, 0);

    // Conflict at index 4 with a dirty line: write-back before fill
    exp_wb(28'h4);
    exp_fill(28'hC);
    access(1, 0, 30'h30, '0, 2);
    access(1, 0, 30'h10 | 30'h20, '0, 0);

    // Slow memory: 10-cycle fill latency
    mem_delay = 10;
    exp_fill(28'h12);
    access(1, 0, 30'h48, '0, 1);
    mem_delay = 2;

    // Write miss allocates, then read hit
    exp_fill(28'h11);
    access(0, 1, 30'h44, 32'h1234_5678, 1);
    access(1, 0, 30'h44, '0, 0);

    // Read+write on a hit acts as a write and marks the line dirty
    access(1, 1, 30'h30, 32'hCAFE_F00D, 0);
    access(1, 0, 30'h30, '0, 0);
    exp_wb(28'hC);
    exp_fill(28'h4);
    access(1, 0, 30'h10, '0, 2);

    // Reset in the middle of a write-back
    access(0, 1, 30'h12, 32'h1111_2222, 0);
    exp_wb(28'h4);
    mem_delay = 20;
    @(posedge clk); #1;
    proc_read = 1'b1; proc_addr = 30'h32;
    repeat (3) @(negedge clk);
    chk("wb_active", {mem_write, proc_stall}, 2'b11);
    chk("wb_addr", mem_addr, 28'h4);
    @(posedge clk); #1;
    rst_n = 1'b0; proc_read = 1'b0;
    @(negedge clk);
    chk("rst_memw", mem_write, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst", {proc_stall, mem_read, mem_write}, 3'b000);
    ref_mem.delete();
    mem_delay = 2;
    chk("mq_after_rst", mq.size(), 0);

    // Same address misses again: clean fill only
    exp_fill(28'hC);
    access(1, 0, 30'h32, '0, 1);
    exp_fill(28'h4);
    access(1, 0, 30'h12, '0, 1);

    repeat (5) @(negedge clk);
    chk("mq_empty", mq.size(), 0);
    chk("final_idle", {proc_stall, mem_read, mem_write}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_d_cache
